// File: rtl/crp16_fetch_unit_pkg.sv
// crp16_fetch_unit_pkg: shared crp16 definitions for the fetch slice.
// Holds the default address/instruction widths, the reset fetch address,
// the no-op encoding and the fetch control FSM state type.
// No ports (package). The include guard makes repeated inclusion harmless.
`ifndef CRP16_FETCH_UNIT_PKG_SV
`define CRP16_FETCH_UNIT_PKG_SV
package crp16_fetch_unit_pkg;
    localparam int CRP16_ADDR_W   = 16;
    localparam int CRP16_INSTR_W  = 16;
    localparam int CRP16_RESET_PC = 0;
    localparam logic [15:0] CRP16_NOP = 16'h0000;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DISCARD} fetch_state_e;
endpackage
`endif

// File: rtl/crp16_sync_fifo.sv
// crp16_sync_fifo: synchronous FIFO holding prefetched instruction entries.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   push_i, data_i    write an entry
//   pop_i             drop the head entry
//   flush_i           empty the FIFO (wins over push/pop)
//   full_o, empty_o   occupancy flags
//   count_o           occupancy
//   data_o            head entry (undefined when empty)
// DEPTH must be a power of two so the pointers wrap naturally.
module crp16_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [WIDTH-1:0]           data_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, wr_q;
    logic [CW-1:0]    cnt_q;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i)
            mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i)
                wr_q <= wr_q + 1'b1;
            if (pop_i)
                rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end
endmodule

// File: rtl/crp16_fetch_unit.sv
// crp16_fetch_unit: CRP16 instruction prefetcher with a small buffer.
// Issues one outstanding memory read at a time, buffers returned
// instructions with their next-PC, and handles redirects (branches/calls),
// dropping the data of a request that was in flight when redirected.
// Ports:
//   clock_i, reset_i              clock, asynchronous active-high reset
//   mem_req_o, mem_addr_o         read request and address (held until ack)
//   mem_ack_i, mem_rdata_i        read completion and data
//   redirect_i, redirect_addr_i   taken branch/call and its target
//   instr_valid_o, instr_o        head instruction
//   instr_next_pc_o               head address + 1
//   instr_ready_i                 consumer takes the head
//   count_o                       buffer occupancy
// Build option: define CRP16_FETCH_BYPASS_EN to forward an ack straight to
// the instr outputs when the buffer is empty (zero-latency fetch).
module crp16_fetch_unit
    import crp16_fetch_unit_pkg::*;
#(
    parameter int ADDR_W   = CRP16_ADDR_W,
    parameter int INSTR_W  = CRP16_INSTR_W,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = CRP16_RESET_PC
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    output logic                       mem_req_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    input  logic                       mem_ack_i,
    input  logic [INSTR_W-1:0]         mem_rdata_i,
    input  logic                       redirect_i,
    input  logic [ADDR_W-1:0]          redirect_addr_i,
    output logic                       instr_valid_o,
    output logic [INSTR_W-1:0]         instr_o,
    output logic [ADDR_W-1:0]          instr_next_pc_o,
    input  logic                       instr_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = INSTR_W + ADDR_W;

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d, tgt_q, tgt_d, addr_inc;
    logic               req_q;
    logic [CW-1:0]      count;
    logic [CW:0]        occ;
    logic [EW-1:0]      head;
    logic               empty, full, ack_ok, bypass, push, pop, room;

    // addr_q is the in-flight address in REQ/DISCARD and the next fetch
    // address in IDLE; tgt_q holds the redirect target while discarding.
    assign addr_inc = addr_q + 1'b1;
    assign ack_ok   = mem_ack_i && state_q == ST_REQ && !redirect_i;
`ifdef CRP16_FETCH_BYPASS_EN
    assign bypass = ack_ok && empty;
`else
    assign bypass = 1'b0;
`endif
    // A bypassed instruction taken in the same cycle never enters the buffer.
    assign push = ack_ok && !(bypass && instr_ready_i) && !full;
    assign pop  = !empty && instr_ready_i && !redirect_i;
    assign occ  = redirect_i ? '0 : {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
    assign room = occ < (CW+1)'(DEPTH);

    crp16_sync_fifo #(
        .WIDTH(EW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .push_i  (push),
        .data_i  ({mem_rdata_i, addr_inc}),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count),
        .data_o  (head)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tgt_d   = tgt_q;
        case (state_q)
            ST_IDLE: begin
                addr_d  = redirect_i ? redirect_addr_i : addr_q;
                state_d = room ? ST_REQ : ST_IDLE;
            end
            ST_REQ: begin
                if (mem_ack_i) begin
                    addr_d  = redirect_i ? redirect_addr_i : addr_inc;
                    state_d = room ? ST_REQ : ST_IDLE;
                end else if (redirect_i) begin
                    tgt_d   = redirect_addr_i;
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                // The buffer was flushed on entry, so there is always room.
                if (mem_ack_i) begin
                    addr_d  = redirect_i ? redirect_addr_i : tgt_q;
                    state_d = ST_REQ;
                end else if (redirect_i) begin
                    tgt_d = redirect_addr_i;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            addr_q  <= ADDR_W'(RESET_PC);
            tgt_q   <= ADDR_W'(RESET_PC);
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tgt_q   <= tgt_d;
            req_q   <= state_d != ST_IDLE;
        end
    end

    assign mem_req_o       = req_q;
    assign mem_addr_o      = addr_q;
    assign count_o         = count;
    assign instr_valid_o   = !empty || bypass;
    assign instr_o         = bypass ? mem_rdata_i : empty ? INSTR_W'(CRP16_NOP) : head[EW-1:ADDR_W];
    assign instr_next_pc_o = bypass ? addr_inc : empty ? '0 : head[ADDR_W-1:0];
endmodule

// File: tb/tb_crp16_fetch_unit.sv
// tb_crp16_fetch_unit: directed plus randomized bench for crp16_fetch_unit
// against a queue-based model of the prefetcher (fetch PC, pending request,
// discard flag, instruction queue).
module tb_crp16_fetch_unit;
    logic        clock = 1'b0, reset = 1'b1;
    logic        mem_req, mem_ack = 1'b0, redirect = 1'b0, instr_valid, instr_ready = 1'b0;
    logic [15:0] mem_addr, mem_rdata = '0, redirect_addr = '0, instr, instr_next_pc;
    logic [2:0]  count;
    int          checks = 0, failures = 0;

    logic [31:0] q[$];
    bit          m_req, m_disc;
    logic [15:0] m_addr, m_pc;

    always #5 clock = ~clock;

    crp16_fetch_unit dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .mem_req_o      (mem_req),
        .mem_addr_o     (mem_addr),
        .mem_ack_i      (mem_ack),
        .mem_rdata_i    (mem_rdata),
        .redirect_i     (redirect),
        .redirect_addr_i(redirect_addr),
        .instr_valid_o  (instr_valid),
        .instr_o        (instr),
        .instr_next_pc_o(instr_next_pc),
        .instr_ready_i  (instr_ready),
        .count_o        (count)
    );

    function automatic logic [15:0] f(input logic [15:0] a);
        return a * 16'd7 + 16'h1234;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit m_byp();
`ifdef CRP16_FETCH_BYPASS_EN
        return m_req && !m_disc && mem_ack && !redirect && q.size() == 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic m_reset();
        q.delete();
        m_req  = 0;
        m_disc = 0;
        m_addr = 16'h0000;
        m_pc   = 16'h0000;
    endtask

    task automatic compare();
        bit b;
        b = m_byp();
        chk("mem_req", 32'(mem_req), 32'(m_req));
        if (m_req) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("count", 32'(count), q.size());
        chk("instr_valid", 32'(instr_valid), 32'(b || q.size() != 0));
        if (b) begin
            chk("instr_byp", 32'(instr), 32'(mem_rdata));
            chk("npc_byp", 32'(instr_next_pc), 32'(m_addr + 16'd1));
        end else if (q.size() != 0) begin
            chk("instr", 32'(instr), 32'(q[0][31:16]));
            chk("npc", 32'(instr_next_pc), 32'(q[0][15:0]));
        end
    endtask

    // One clock edge of the model, applied with the inputs of the cycle.
    task automatic step();
        bit b, comp;
        if (reset) return;
        b    = m_byp();
        comp = m_req && mem_ack;
        if (redirect) begin
            q.delete();
            m_pc   = redirect_addr;
            m_disc = m_req && !mem_ack;
        end else begin
            if (q.size() != 0 && instr_ready) void'(q.pop_front());
            if (comp) begin
                if (m_disc) m_disc = 0;
                else begin
                    if (!(b && instr_ready)) q.push_back({mem_rdata, m_addr + 16'd1});
                    m_pc = m_addr + 16'd1;
                end
            end
        end
        if (!(m_req && !mem_ack)) begin
            m_req = q.size() < 4;
            if (m_req) m_addr = m_pc;
        end
    endtask

    task automatic set_in(input bit a, input bit r, input logic [15:0] ra, input bit rd);
        mem_ack       = a && mem_req;
        mem_rdata     = mem_ack ? f(mem_addr) : 16'($urandom);
        redirect      = r;
        redirect_addr = ra;
        instr_ready   = rd;
        #1;
    endtask

    task automatic tick();
        compare();
        @(posedge clock);
        step();
        @(negedge clock);
    endtask

    task automatic cy(input bit a, input bit r, input logic [15:0] ra, input bit rd);
        set_in(a, r, ra, rd);
        tick();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'($urandom);
        redirect  = 1'b0;
        #1;
        m_reset();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", 32'(instr), 0);
        chk("rst_npc", 32'(instr_next_pc), 0);
        repeat (2) tick();
        reset   = 1'b0;
        mem_ack = 1'b0;
    endtask

    initial begin
        int acks;
        logic [15:0] ra;
        m_reset();
        do_reset();

        // zero-wait memory, always ready
        set_in(1, 0, 0, 1); tick();
        set_in(1, 0, 0, 1);
        chk("zw_addr0", 32'(mem_addr), 32'h0000);
        chk("zw_req0", 32'(mem_req), 1);
`ifdef CRP16_FETCH_BYPASS_EN
        chk("zw_valid1", 32'(instr_valid), 1);
`else
        chk("zw_valid1", 32'(instr_valid), 0);
`endif
        tick();
        set_in(1, 0, 0, 1);
        chk("zw_addr1", 32'(mem_addr), 32'h0001);
        chk("zw_valid2", 32'(instr_valid), 1);
`ifdef CRP16_FETCH_BYPASS_EN
        chk("zw_instr2", 32'(instr), 32'h123B);
        chk("zw_npc2", 32'(instr_next_pc), 32'h0002);
`else
        chk("zw_instr2", 32'(instr), 32'h1234);
        chk("zw_npc2", 32'(instr_next_pc), 32'h0001);
`endif
        tick();
        repeat (5) cy(1, 0, 0, 1);
        chk("zw_addr7", 32'(mem_addr), 32'h0007);

        // backpressure fills the buffer with exactly DEPTH entries
        do_reset();
        acks = 0;
        repeat (9) begin
            set_in(1, 0, 0, 0);
            if (mem_ack) acks++;
            tick();
        end
        chk("bp_acks", 32'(acks), 4);
        chk("bp_count", 32'(count), 4);
        chk("bp_req", 32'(mem_req), 0);
        chk("bp_head", 32'(instr), 32'h1234);
        cy(1, 0, 0, 1);
        chk("bp_resume_req", 32'(mem_req), 1);
        chk("bp_resume_addr", 32'(mem_addr), 32'h0004);
        chk("bp_head2", 32'(instr_next_pc), 32'h0002);
        repeat (8) cy(1, 0, 0, 1);

        // redirect during a wait at 0x0005
        do_reset();
        repeat (6) cy(1, 0, 0, 1);
        chk("rw_addr5", 32'(mem_addr), 32'h0005);
        cy(0, 0, 0, 1);
        cy(0, 1, 16'h0100, 1);
        cy(1, 0, 0, 1);
        chk("rw_addr", 32'(mem_addr), 32'h0100);
        chk("rw_count", 32'(count), 0);
        cy(1, 0, 0, 0);
        chk("rw_valid", 32'(instr_valid), 1);
        chk("rw_npc", 32'(instr_next_pc), 32'h0101);

        // redirect in the ack cycle, then a second one while discarding
        cy(1, 1, 16'h0200, 0);
        chk("ra_count", 32'(count), 0);
        chk("ra_addr", 32'(mem_addr), 32'h0200);
        cy(0, 1, 16'h0300, 0);
        cy(1, 0, 0, 0);
        chk("ra_count2", 32'(count), 0);
        chk("ra_addr2", 32'(mem_addr), 32'h0300);
        cy(1, 0, 0, 0);
        chk("ra_count3", 32'(count), 1);
        chk("ra_instr", 32'(instr), 32'h2734);
        chk("ra_npc", 32'(instr_next_pc), 32'h0301);

        // address wrap
        cy(0, 1, 16'hFFFF, 0);
        cy(1, 0, 0, 0);
        chk("wr_addr", 32'(mem_addr), 32'hFFFF);
        cy(1, 0, 0, 0);
        chk("wr_addr2", 32'(mem_addr), 32'h0000);
        cy(1, 0, 0, 0);
        chk("wr_count", 32'(count), 2);
        chk("wr_instr", 32'(instr), 32'h122D);
        chk("wr_npc", 32'(instr_next_pc), 32'h0000);

        // ack into an empty buffer with ready high
        do_reset();
        cy(0, 0, 0, 1);
        set_in(1, 0, 0, 1);
`ifdef CRP16_FETCH_BYPASS_EN
        chk("by_valid", 32'(instr_valid), 1);
`else
        chk("by_valid", 32'(instr_valid), 0);
`endif
        chk("by_count", 32'(count), 0);
        tick();
        set_in(0, 0, 0, 1);
`ifdef CRP16_FETCH_BYPASS_EN
        chk("by_valid2", 32'(instr_valid), 0);
        chk("by_count2", 32'(count), 0);
`else
        chk("by_valid2", 32'(instr_valid), 1);
        chk("by_count2", 32'(count), 1);
`endif
        tick();

        // randomized traffic with a mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            case ($urandom_range(0, 3))
                0: ra = 16'hFFFF;
                1: ra = 16'hFFFE;
                default: ra = 16'($urandom);
            endcase
            cy($urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0, ra,
               (i % 400 < 300) ? ($urandom_range(0, 9) < 6) : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/crp16_fetch_unit.md
CRP16_FETCH_UNIT -- requirements
Module: crp16_fetch_unit

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 16, instruction address width.
- INSTR_W, 16, instruction width.
- DEPTH, 4, prefetch buffer entries; power of 2, minimum 2.
- RESET_PC, 0, first fetch address after reset.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clock, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, asynchronous, active-high.
- mem_req, out, 1, instruction read request.
- mem_addr, out, ADDR_W, request address.
- mem_ack, in, 1, read complete; mem_rdata valid in the same cycle.
- mem_rdata, in, INSTR_W, read data.
- redirect, in, 1, branch or call taken.
- redirect_addr, in, ADDR_W, new fetch address.
- instr_valid, out, 1, buffer head valid.
- instr, out, INSTR_W, head instruction.
- instr_next_pc, out, ADDR_W, head address + 1, used for PC-relative branch targets.
- instr_ready, in, 1, consumer takes head.
- count, out, clog2(DEPTH+1), buffer occupancy.

Function
REQ-003 Requests: at most one outstanding; once mem_req is asserted, mem_req and mem_addr SHALL hold stable until the mem_ack cycle.
REQ-004 Issue: mem_req SHALL be registered, set at an edge when (occupancy after this edge's push/pop) < DEPTH and no unacked request remains.
- Zero-wait memory SHALL sustain one fetch per cycle.
REQ-005 Ack without discard: push {mem_rdata, mem_addr+1} at the edge; fetch address increments mod 2^ADDR_W (0xFFFF -> 0x0000 at ADDR_W=16).
REQ-006 Latency: mem_ack in cycle n -> instr_valid high in cycle n+1, with bypass compiled out.
REQ-007 Output: instr_valid = (count != 0); instr and instr_next_pc SHALL be the head entry.
- A pop occurs when instr_valid & instr_ready.
- Push and pop in the same cycle leave count unchanged.
REQ-008 Overflow: a push SHALL never occur when count == DEPTH; REQ-004 guarantees this.
REQ-009 Redirect, priority over all other events:
- Flush the buffer; count = 0 next cycle.
- The same-cycle pop is ignored.
- Fetch address := redirect_addr.
REQ-010 Redirect with an unacked request: set discard; mem_req stays asserted at the old address until ack.
- That ack's data SHALL be dropped and discard cleared.
- Next request SHALL go to redirect_addr.
REQ-011 Redirect in the ack cycle: ack data is dropped; next request goes to redirect_addr on the following cycle.
REQ-012 Redirect while discard is set: the target is updated to the latest redirect_addr; discard stays set.
REQ-013 Idle redirect (no request outstanding): mem_req=1, mem_addr=redirect_addr in the next cycle.

Reset
REQ-014 While reset is asserted:
- mem_req=0, mem_addr=RESET_PC.
- count=0, instr_valid=0, discard=0.
- instr and instr_next_pc = 0.
REQ-015 The first rising edge after reset release SHALL assert mem_req at RESET_PC.
REQ-016 Reset mid-request SHALL abandon the request; mem_ack received while in reset is ignored.

Configuration
REQ-017 Macro CRP16_FETCH_BYPASS_EN.
- Defined: when the buffer is empty, mem_ack=1, discard=0 and redirect=0, then:
  - instr_valid=1, instr=mem_rdata, instr_next_pc=mem_addr+1 combinationally in the same cycle.
  - If instr_ready=1, the entry is not pushed.
  - Otherwise it is pushed as normal.
- Undefined: no combinational path from mem_* to instr_*; latency per REQ-006.

Structure
REQ-018 Default widths, RESET_PC default and the no-op encoding 16'h0000 SHALL live in the shared crp16 definitions header, include-guarded.
REQ-019 Buffer storage and pointers SHALL be sub-module crp16_sync_fifo (parameters WIDTH, DEPTH; ports push, pop, flush, full, empty, count).
- The fetch control FSM (IDLE, REQ, DISCARD) SHALL stay in crp16_fetch_unit.

Verification
REQ-020 Reset, zero-wait memory: ack every cycle a request is pending, instr_ready=1.
- Expect addresses 0,1,2,...; first instr_valid at cycle 2 after release; one instruction per cycle thereafter.
REQ-021 Backpressure: instr_ready=0, DEPTH=4.
- Expect exactly 4 acks, count=4, mem_req=0.
- Raise ready: fetch resumes at address 4, data in order.
REQ-022 Redirect during a 3-cycle wait: redirect to 0x0100 while a request at 0x0005 is pending.
- 0x0005 data is never output.
- Next mem_addr=0x0100.
- First output instr_next_pc=0x0101.
REQ-023 Redirect in the ack cycle plus a second redirect during discard (0x0200, then 0x0300).
- Only 0x0300 is fetched; count=0 after the first redirect.
REQ-024 Wrap: redirect to 0xFFFF.
- Expect fetches 0xFFFF then 0x0000; head instr_next_pc=0x0000.
REQ-025 With CRP16_FETCH_BYPASS_EN, empty buffer, ack with ready=1:
- instr valid in the ack cycle; count stays 0.
- Repeat with the macro undefined: valid one cycle later.
